// File: rtl/prng_sched_pkg.sv
// Shared types and constants for the PRNG request scheduler.
package prng_sched_pkg;

  // RUN fills the prefetch FIFO and grants; SEED holds everything off until
  // the last seed word has reached the core.
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    SEED = 1'b1
  } sched_state_e;

  localparam int         SEED_WORDS    = 4;
  localparam logic [1:0] LAST_SEED_IDX = 2'd3;

endpackage

// File: rtl/prng_word_fifo.sv
// Prefetch FIFO for generator words: push/pop/flush with a level count.
// Flush wins over push and pop in the same cycle.
module prng_word_fifo
  import prng_sched_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [DATA_W-1:0]          pop_data,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              do_push;
  logic              do_pop;
  logic              mem_we;

  // Pointer and level update; overflow pushes and empty pops are ignored.
  always_comb begin
    do_push  = push && (level_q < LW'(DEPTH));
    do_pop   = pop && (level_q != '0);
    mem_we   = do_push && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  // Control state is reset; storage is not.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Word storage, written at the tail.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign level    = level_q;

endmodule

// File: rtl/prng_req_scheduler.sv
// Shares one xoshiro128++ core between NUM_REQ requesters: keeps a prefetch
// FIFO topped up, hands words out round-robin and sequences seed loading so
// that words generated under an old seed are never delivered.
module prng_req_scheduler
  import prng_sched_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [31:0]               rnd_out,
  input  logic                      seed_wr,
  input  logic [1:0]                seed_idx,
  input  logic [31:0]               seed_data,
  output logic                      seed_busy,
  output logic [$clog2(DEPTH):0]    fifo_level,
  input  logic [31:0]               core_rnd,
  input  logic                      core_valid,
  output logic                      core_next,
  output logic                      core_write,
  output logic [1:0]                core_write_addr,
  output logic [31:0]               core_write_data
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(NUM_REQ);

  sched_state_e         state_q, state_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [31:0]          rnd_q, rnd_d;

  logic [LW-1:0]        level;
  logic [31:0]          head;
  logic                 run;
  logic                 fill;
  logic                 arb_en;
  logic                 found;
  logic                 win;
  logic [PW-1:0]        winner;
  logic [NUM_REQ-1:0]   elig;

  prng_word_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (32)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fill),
    .push_data (core_rnd),
    .pop       (win),
    .flush     (seed_wr),
    .pop_data  (head),
    .level     (level)
  );

  // Fill and seed passthrough; the level test uses the pre-pop occupancy,
  // so a full FIFO that pops this cycle refills on the next one.
  always_comb begin
    run        = rst_n && (state_q == RUN);
    fill       = run && core_valid && (level < LW'(DEPTH)) && !seed_wr;
    core_next  = fill;
    core_write = rst_n && seed_wr;
  end

  // Round-robin pick among requesters not granted last cycle; a seed write
  // in the same cycle suppresses the grant.
  always_comb begin
    elig     = req & ~gnt_q;
    arb_en   = run && (level != '0) && !seed_wr;
    found    = 1'b0;
    winner   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
    win      = arb_en && found;
    gnt_d    = '0;
    rnd_d    = rnd_q;
    rr_ptr_d = rr_ptr_q;
    if (win) begin
      gnt_d[winner] = 1'b1;
      rnd_d         = head;
      rr_ptr_d      = (int'(winner) == NUM_REQ - 1) ? '0 : winner + PW'(1);
    end
  end

  // Seed sequencing: any write enters SEED; the index-3 write releases it.
  always_comb begin
    state_d = state_q;
    if (seed_wr) begin
      if (state_q == RUN)                  state_d = SEED;
      else if (seed_idx == LAST_SEED_IDX)  state_d = RUN;
    end
  end

  // Registered state, grant and output word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      rnd_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      rnd_q    <= rnd_d;
    end
  end

  assign gnt             = gnt_q;
  assign rnd_out         = rnd_q;
  assign seed_busy       = (state_q == SEED);
  assign fifo_level      = level;
  assign core_write_addr = seed_idx;
  assign core_write_data = seed_data;

endmodule
